// File: rtl/ctrl_sequencer_if.sv
// Decoder/datapath side of the accumulator-processor control unit.
// master = sequencer (reads instruction fields, drives strobes); slave = datapath.
interface ctrl_sequencer_if #(
   parameter int IR_BYTES = 4
);
   logic [2:0]          op_class;
   logic [1:0]          addr_mode;
   logic [1:0]          shift_kind;
   logic                dst_reg;
   logic                zero;
   logic                mem_ready;

   logic                memread;
   logic                memwrite;
   logic                ldAB;
   logic                ldBB;
   logic                ldSP;
   logic                pcwrite;
   logic                regwrite;
   logic                wrCPU;
   logic [IR_BYTES-1:0] irwrite;
   logic [1:0]          adrend;
   logic [1:0]          adrsrc;
   logic [1:0]          alusrca;
   logic [1:0]          alusrcb;
   logic [1:0]          stekSRC;
   logic [1:0]          srcmdr;
   logic [1:0]          pcsrc;
   logic [1:0]          aluop;
   logic [1:0]          branch;
   logic [2:0]          shiftsrc;
   logic [5:0]          state;
   logic                halted;
   logic                timeout;

   modport master (
      input  op_class, addr_mode, shift_kind, dst_reg, zero, mem_ready,
      output memread, memwrite, ldAB, ldBB, ldSP, pcwrite, regwrite, wrCPU,
             irwrite, adrend, adrsrc, alusrca, alusrcb, stekSRC, srcmdr,
             pcsrc, aluop, branch, shiftsrc, state, halted, timeout
   );

   modport slave (
      output op_class, addr_mode, shift_kind, dst_reg, zero, mem_ready,
      input  memread, memwrite, ldAB, ldBB, ldSP, pcwrite, regwrite, wrCPU,
             irwrite, adrend, adrsrc, alusrca, alusrcb, stekSRC, srcmdr,
             pcsrc, aluop, branch, shiftsrc, state, halted, timeout
   );
endinterface

// File: rtl/ctrl_sequencer.sv
// Multicycle Moore control unit: variable-length fetch, memory wait/timeout, branch sequencing.
// Define CTRL_STACK_EN to build the push/pop states; otherwise op_class 5/6 traps to ERR.
module ctrl_sequencer #(
   parameter int IR_BYTES = 4,
   parameter int WAIT_MAX = 15
) (
   input logic             clk,
   input logic             reset,
   ctrl_sequencer_if.master bus
);
   localparam int WW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

   localparam logic [5:0] SPINIT = 6'd0;
   localparam logic [5:0] FETCH0 = 6'd1;
   localparam logic [5:0] FETCH1 = 6'd2;
   localparam logic [5:0] FETCH2 = 6'd3;
   localparam logic [5:0] FETCH3 = 6'd4;
   localparam logic [5:0] DECODE = 6'd5;
   localparam logic [5:0] OPIMM  = 6'd6;
   localparam logic [5:0] OPREG  = 6'd7;
   localparam logic [5:0] MEM1   = 6'd8;
   localparam logic [5:0] MEM2   = 6'd9;
   localparam logic [5:0] PCR1   = 6'd10;
   localparam logic [5:0] PCR2   = 6'd11;
   localparam logic [5:0] PCR3   = 6'd12;
   localparam logic [5:0] PCR4   = 6'd13;
   localparam logic [5:0] PCR5   = 6'd14;
   localparam logic [5:0] ALURES = 6'd15;
   localparam logic [5:0] WB     = 6'd16;
   localparam logic [5:0] SHIFT  = 6'd17;
   localparam logic [5:0] SHRES  = 6'd18;
   localparam logic [5:0] JMP    = 6'd19;
   localparam logic [5:0] BZ     = 6'd20;
   localparam logic [5:0] BNZ    = 6'd21;
`ifdef CTRL_STACK_EN
   localparam logic [5:0] PUSH1  = 6'd22;
   localparam logic [5:0] PUSH2  = 6'd23;
   localparam logic [5:0] POP1   = 6'd24;
   localparam logic [5:0] POP2   = 6'd25;
   localparam logic [5:0] POP3   = 6'd26;
`endif
   localparam logic [5:0] PCINC  = 6'd27;
   localparam logic [5:0] HALT   = 6'd31;
   localparam logic [5:0] ERR    = 6'd63;

   localparam logic [5:0] FETCH_LAST = FETCH0 + 6'(IR_BYTES - 1);

   logic [5:0]          state_reg, state_next, adv_state;
   logic [WW-1:0]       wait_reg, wait_next;
   logic                is_mem;
   logic                fetch_ok;
   logic [IR_BYTES-1:0] irw;

   assign fetch_ok = (state_reg >= FETCH0) && (state_reg <= FETCH_LAST);

   // adv_state is where the state goes once any memory access has completed
   always_comb begin
      adv_state = SPINIT;
      is_mem    = 1'b0;
      case (state_reg)
         SPINIT: adv_state = FETCH0;
         FETCH0, FETCH1, FETCH2, FETCH3: begin
            if (fetch_ok) begin
               is_mem    = 1'b1;
               adv_state = (state_reg == FETCH_LAST) ? DECODE : state_reg + 6'd1;
            end
         end
         DECODE: begin
            case (bus.op_class)
               3'd0, 3'd1: begin
                  case (bus.addr_mode)
                     2'd0:    adv_state = OPIMM;
                     2'd1:    adv_state = OPREG;
                     2'd2:    adv_state = MEM1;
                     default: adv_state = PCR1;
                  endcase
               end
               3'd2: adv_state = JMP;
               3'd3: adv_state = BZ;
               3'd4: adv_state = BNZ;
`ifdef CTRL_STACK_EN
               3'd5: adv_state = PUSH1;
               3'd6: adv_state = POP1;
`else
               3'd5, 3'd6: adv_state = ERR;
`endif
               default: adv_state = HALT;
            endcase
         end
         OPIMM, OPREG, MEM2, PCR5:
            adv_state = (bus.op_class == 3'd1) ? SHIFT : ALURES;
         MEM1: begin
            is_mem    = 1'b1;
            adv_state = MEM2;
         end
         PCR1, PCR2, PCR3: adv_state = state_reg + 6'd1;
         PCR4: begin
            is_mem    = 1'b1;
            adv_state = PCR5;
         end
         ALURES: adv_state = bus.dst_reg ? WB : PCINC;
         WB:     adv_state = PCINC;
         SHIFT:  adv_state = SHRES;
         SHRES:  adv_state = PCINC;
         JMP:    adv_state = FETCH0;
         BZ:     adv_state = bus.zero ? FETCH0 : PCINC;
         BNZ:    adv_state = bus.zero ? PCINC : FETCH0;
`ifdef CTRL_STACK_EN
         PUSH1: begin
            is_mem    = 1'b1;
            adv_state = PUSH2;
         end
         PUSH2: adv_state = PCINC;
         POP1:  adv_state = POP2;
         POP2: begin
            is_mem    = 1'b1;
            adv_state = POP3;
         end
         POP3:  adv_state = PCINC;
`endif
         PCINC:  adv_state = FETCH0;
         HALT:   adv_state = HALT;
         ERR:    adv_state = ERR;
         default: adv_state = SPINIT;
      endcase
   end

   // A ready on the last permitted wait cycle still wins over the timeout
   always_comb begin
      state_next = adv_state;
      wait_next  = '0;
      if (is_mem && !bus.mem_ready) begin
         if (wait_reg == WW'(WAIT_MAX)) begin
            state_next = ERR;
         end else begin
            state_next = state_reg;
            wait_next  = wait_reg + WW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= SPINIT;
         wait_reg  <= '0;
      end else begin
         state_reg <= state_next;
         wait_reg  <= wait_next;
      end
   end

   generate
      for (genvar gi = 0; gi < IR_BYTES; gi++) begin : g_irw
         assign irw[gi] = (state_reg == FETCH0 + 6'(gi));
      end
   endgenerate

   logic       memread, memwrite, ldAB, ldBB, ldSP, pcwrite, regwrite, wrCPU;
   logic [1:0] adrend, adrsrc, alusrca, alusrcb, stekSRC, srcmdr, pcsrc, aluop, branch;
   logic [2:0] shiftsrc;
   logic       halted, timeout;

   always_comb begin
      {memread, memwrite, ldAB, ldBB, ldSP, pcwrite, regwrite, wrCPU} = '0;
      {adrend, adrsrc, alusrca, alusrcb, stekSRC, srcmdr, pcsrc, aluop, branch} = '0;
      shiftsrc = 3'd0;
      halted   = 1'b0;
      timeout  = 1'b0;
      case (state_reg)
         SPINIT: ldSP = 1'b1;
         FETCH0, FETCH1, FETCH2, FETCH3: begin
            if (fetch_ok) begin
               memread = 1'b1;
               alusrcb = 2'b01;
               adrend  = 2'(state_reg - FETCH0);
            end
         end
         OPIMM:  begin alusrcb = 2'b11; ldBB = 1'b1; end
         OPREG:  ldBB = 1'b1;
         MEM1:   begin adrsrc = 2'b01; memread = 1'b1; end
         MEM2:   begin alusrcb = 2'b01; ldBB = 1'b1; end
         PCR1:   begin alusrcb = 2'b10; ldBB = 1'b1; ldAB = 1'b1; end
         PCR2:   begin alusrcb = 2'b11; ldBB = 1'b1; aluop = 2'b01; end
         PCR3:   begin alusrca = 2'b01; ldAB = 1'b1; end
         PCR4:   begin adrsrc = 2'b10; memread = 1'b1; end
         PCR5:   begin alusrcb = 2'b01; ldBB = 1'b1; end
         ALURES: begin alusrca = 2'b01; ldAB = 1'b1; end
         WB:     regwrite = 1'b1;
         SHIFT:  shiftsrc = {1'b0, bus.shift_kind} + 3'd1;
         SHRES:  begin alusrca = 2'b10; ldAB = 1'b1; end
         JMP:    begin pcsrc = 2'b10; pcwrite = 1'b1; end
         BZ:     begin pcsrc = 2'b10; branch = 2'b01; end
         BNZ:    begin pcsrc = 2'b10; branch = 2'b10; end
`ifdef CTRL_STACK_EN
         PUSH1:  begin adrsrc = 2'b11; srcmdr = 2'b01; wrCPU = 1'b1; memwrite = 1'b1; end
         PUSH2:  begin stekSRC = 2'b10; ldSP = 1'b1; end
         POP1:   begin stekSRC = 2'b01; ldSP = 1'b1; end
         POP2:   begin adrsrc = 2'b11; memread = 1'b1; end
         POP3:   begin alusrcb = 2'b01; ldBB = 1'b1; ldAB = 1'b1; end
`endif
         PCINC:  begin pcsrc = 2'b01; pcwrite = 1'b1; end
         HALT:   halted = 1'b1;
         ERR:    timeout = 1'b1;
         default: ;
      endcase
   end

   assign bus.memread  = memread;
   assign bus.memwrite = memwrite;
   assign bus.ldAB     = ldAB;
   assign bus.ldBB     = ldBB;
   assign bus.ldSP     = ldSP;
   assign bus.pcwrite  = pcwrite;
   assign bus.regwrite = regwrite;
   assign bus.wrCPU    = wrCPU;
   assign bus.irwrite  = irw;
   assign bus.adrend   = adrend;
   assign bus.adrsrc   = adrsrc;
   assign bus.alusrca  = alusrca;
   assign bus.alusrcb  = alusrcb;
   assign bus.stekSRC  = stekSRC;
   assign bus.srcmdr   = srcmdr;
   assign bus.pcsrc    = pcsrc;
   assign bus.aluop    = aluop;
   assign bus.branch   = branch;
   assign bus.shiftsrc = shiftsrc;
   assign bus.state    = state_reg;
   assign bus.halted   = halted;
   assign bus.timeout  = timeout;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: instruction table with a per-cycle strobe scoreboard (IR_BYTES=4,
// WAIT_MAX=15) plus hand sequences for waits, timeout, halt, stack and reset (second DUT: 3/4).
module tb_ctrl_sequencer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_a, reset_b;
   ctrl_sequencer_if #(.IR_BYTES(4)) bus_a();
   ctrl_sequencer_if #(.IR_BYTES(3)) bus_b();

   ctrl_sequencer #(.IR_BYTES(4), .WAIT_MAX(15)) dut_a (.clk(clk), .reset(reset_a), .bus(bus_a));
   ctrl_sequencer #(.IR_BYTES(3), .WAIT_MAX(4))  dut_b (.clk(clk), .reset(reset_b), .bus(bus_b));

   typedef enum {S_SPINIT, S_F0, S_F1, S_F2, S_F3, S_DEC, S_OPIMM, S_OPREG, S_MEM1, S_MEM2,
                 S_PCR1, S_PCR2, S_PCR3, S_PCR4, S_PCR5, S_ALURES, S_WB, S_SHIFT, S_SHRES,
                 S_JMP, S_BZ, S_BNZ, S_PUSH1, S_PUSH2, S_POP1, S_POP2, S_POP3, S_PCINC,
                 S_HALT, S_ERR} step_t;

   typedef struct {
      logic [2:0] op;
      logic [1:0] am;
      logic [1:0] sk;
      logic       dst;
      logic       z;
      int         cycles;
   } vec_t;

   int         n_checks = 0;
   int         n_fail   = 0;
   step_t      sb[$];
   logic [1:0] cur_sk;

   logic [34:0] act_a;
   assign act_a = {bus_a.irwrite, bus_a.memread, bus_a.memwrite, bus_a.ldAB, bus_a.ldBB,
                   bus_a.ldSP, bus_a.pcwrite, bus_a.regwrite, bus_a.wrCPU, bus_a.adrend,
                   bus_a.adrsrc, bus_a.alusrca, bus_a.alusrcb, bus_a.stekSRC, bus_a.srcmdr,
                   bus_a.pcsrc, bus_a.aluop, bus_a.branch, bus_a.shiftsrc, bus_a.halted,
                   bus_a.timeout};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: bound expired or sequence broken", name);
   endtask

   // Expected strobe word for one control step, straight from the state table
   function automatic logic [34:0] exp_vec(input step_t s, input logic [1:0] sk);
      logic [3:0] irw;
      logic mr, mw, lab, lbb, lsp, pcw, rw, wc, h, t;
      logic [1:0] ae, as, aa, ab, ss, sm, ps, ao, br;
      logic [2:0] sh;
      irw = '0; {mr, mw, lab, lbb, lsp, pcw, rw, wc, h, t} = '0;
      {ae, as, aa, ab, ss, sm, ps, ao, br} = '0; sh = '0;
      case (s)
         S_SPINIT: lsp = 1;
         S_F0:     begin mr = 1; irw = 4'b0001; ab = 2'b01; ae = 2'd0; end
         S_F1:     begin mr = 1; irw = 4'b0010; ab = 2'b01; ae = 2'd1; end
         S_F2:     begin mr = 1; irw = 4'b0100; ab = 2'b01; ae = 2'd2; end
         S_F3:     begin mr = 1; irw = 4'b1000; ab = 2'b01; ae = 2'd3; end
         S_OPIMM:  begin ab = 2'b11; lbb = 1; end
         S_OPREG:  lbb = 1;
         S_MEM1:   begin as = 2'b01; mr = 1; end
         S_MEM2:   begin ab = 2'b01; lbb = 1; end
         S_PCR1:   begin ab = 2'b10; lbb = 1; lab = 1; end
         S_PCR2:   begin ab = 2'b11; lbb = 1; ao = 2'b01; end
         S_PCR3:   begin aa = 2'b01; lab = 1; end
         S_PCR4:   begin as = 2'b10; mr = 1; end
         S_PCR5:   begin ab = 2'b01; lbb = 1; end
         S_ALURES: begin aa = 2'b01; lab = 1; end
         S_WB:     rw = 1;
         S_SHIFT:  sh = {1'b0, sk} + 3'd1;
         S_SHRES:  begin aa = 2'b10; lab = 1; end
         S_JMP:    begin ps = 2'b10; pcw = 1; end
         S_BZ:     begin ps = 2'b10; br = 2'b01; end
         S_BNZ:    begin ps = 2'b10; br = 2'b10; end
         S_PUSH1:  begin as = 2'b11; sm = 2'b01; wc = 1; mw = 1; end
         S_PUSH2:  begin ss = 2'b10; lsp = 1; end
         S_POP1:   begin ss = 2'b01; lsp = 1; end
         S_POP2:   begin as = 2'b11; mr = 1; end
         S_POP3:   begin ab = 2'b01; lbb = 1; lab = 1; end
         S_PCINC:  begin ps = 2'b01; pcw = 1; end
         S_HALT:   h = 1;
         S_ERR:    t = 1;
         default:  ;
      endcase
      return {irw, mr, mw, lab, lbb, lsp, pcw, rw, wc, ae, as, aa, ab, ss, sm, ps, ao, br,
              sh, h, t};
   endfunction

   function automatic void push_seq(input logic [2:0] op, input logic [1:0] am,
                                    input logic dst, input logic z);
      sb.push_back(S_F0); sb.push_back(S_F1); sb.push_back(S_F2); sb.push_back(S_F3);
      sb.push_back(S_DEC);
      case (op)
         3'd0, 3'd1: begin
            case (am)
               2'd0: sb.push_back(S_OPIMM);
               2'd1: sb.push_back(S_OPREG);
               2'd2: begin sb.push_back(S_MEM1); sb.push_back(S_MEM2); end
               default: begin
                  sb.push_back(S_PCR1); sb.push_back(S_PCR2); sb.push_back(S_PCR3);
                  sb.push_back(S_PCR4); sb.push_back(S_PCR5);
               end
            endcase
            if (op == 3'd0) begin
               sb.push_back(S_ALURES);
               if (dst) sb.push_back(S_WB);
            end else begin
               sb.push_back(S_SHIFT); sb.push_back(S_SHRES);
            end
            sb.push_back(S_PCINC);
         end
         3'd2: sb.push_back(S_JMP);
         3'd3: begin sb.push_back(S_BZ); if (!z) sb.push_back(S_PCINC); end
         3'd4: begin sb.push_back(S_BNZ); if (z) sb.push_back(S_PCINC); end
         3'd5: begin sb.push_back(S_PUSH1); sb.push_back(S_PUSH2); sb.push_back(S_PCINC); end
         3'd6: begin
            sb.push_back(S_POP1); sb.push_back(S_POP2); sb.push_back(S_POP3);
            sb.push_back(S_PCINC);
         end
         default: ;
      endcase
   endfunction

   task automatic sb_check();
      step_t s;
      if (sb.size() == 0) begin
         fail("scoreboard_underflow");
      end else begin
         s = sb.pop_front();
         check(s.name(), 64'(act_a), 64'(exp_vec(s, cur_sk)));
      end
   endtask

   task automatic reset_a_seq();
      reset_a = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("rst_state", 64'(bus_a.state), 64'd0);
         check("rst_strobes", 64'(act_a), 64'(exp_vec(S_SPINIT, 2'd0)));
      end
      reset_a = 1'b0;
   endtask

   task automatic wait_fetch0_a(input string name);
      int n;
      n = 0;
      while (bus_a.irwrite != 4'b0001 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) fail(name);
   endtask

   task automatic mem1_wait(input int held);
      int cnt;
      bus_a.op_class = 3'd0; bus_a.addr_mode = 2'd2; bus_a.dst_reg = 1'b0;
      bus_a.mem_ready = 1'b1;
      repeat (4) @(negedge clk);
      check("decode_idle", 64'(act_a), 64'(exp_vec(S_DEC, 2'd0)));
      bus_a.mem_ready = 1'b0;
      @(negedge clk);
      cnt = 0;
      while (bus_a.memread && bus_a.adrsrc == 2'b01 && cnt < 40) begin
         cnt++;
         if (cnt == held + 1) bus_a.mem_ready = 1'b1;
         @(negedge clk);
      end
      bus_a.mem_ready = 1'b1;
      check($sformatf("mem1_cycles_w%0d", held), 64'(cnt), 64'(held + 1));
      check($sformatf("mem2_after_w%0d", held), 64'(act_a), 64'(exp_vec(S_MEM2, 2'd0)));
      $display("mem1 wait %0d: MEM1 held %0d cycles", held, cnt);
      wait_fetch0_a("mem1_return");
   endtask

`ifdef CTRL_STACK_EN
   task automatic stack_op(input logic [2:0] op, input int exp_cycles);
      int cyc, holds, nsp, nhold;
      logic [1:0] sp_src;
      logic in_mem;
      cyc = 0; holds = 0; nsp = 0; nhold = 0; sp_src = 2'b00;
      bus_a.op_class = op;
      do begin
         in_mem = (op == 3'd5) ? bus_a.memwrite : (bus_a.memread && bus_a.adrsrc == 2'b11);
         if (in_mem) nhold++;
         if (in_mem && holds < 2) begin
            bus_a.mem_ready = 1'b0;
            holds++;
         end else begin
            bus_a.mem_ready = 1'b1;
         end
         if (bus_a.ldSP) begin nsp++; sp_src = bus_a.stekSRC; end
         cyc++;
         @(negedge clk);
      end while (bus_a.irwrite != 4'b0001 && cyc < 40);
      bus_a.mem_ready = 1'b1;
      check($sformatf("op%0d_ldsp_pulses", op), 64'(nsp), 64'd1);
      check($sformatf("op%0d_steksrc", op), 64'(sp_src), (op == 3'd5) ? 64'd2 : 64'd1);
      check($sformatf("op%0d_mem_cycles", op), 64'(nhold), 64'd3);
      check($sformatf("op%0d_cycles", op), 64'(cyc), 64'(exp_cycles));
      $display("stack op %0d: cycles=%0d ldSP pulses=%0d", op, cyc, nsp);
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[$];
      int   cyc, cnt;
      logic done;

      vecs.push_back('{3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 8});
      vecs.push_back('{3'd0, 2'd0, 2'd0, 1'b1, 1'b0, 9});
      vecs.push_back('{3'd0, 2'd1, 2'd0, 1'b0, 1'b0, 8});
      vecs.push_back('{3'd0, 2'd2, 2'd0, 1'b1, 1'b0, 10});
      vecs.push_back('{3'd0, 2'd3, 2'd0, 1'b0, 1'b0, 12});
      vecs.push_back('{3'd1, 2'd3, 2'd0, 1'b0, 1'b0, 13});
      vecs.push_back('{3'd1, 2'd0, 2'd2, 1'b0, 1'b0, 9});
      vecs.push_back('{3'd1, 2'd2, 2'd3, 1'b1, 1'b0, 10});
      vecs.push_back('{3'd1, 2'd1, 2'd1, 1'b0, 1'b1, 9});
      vecs.push_back('{3'd2, 2'd0, 2'd0, 1'b0, 1'b0, 6});
      vecs.push_back('{3'd3, 2'd0, 2'd0, 1'b0, 1'b1, 6});
      vecs.push_back('{3'd3, 2'd0, 2'd0, 1'b0, 1'b0, 7});
      vecs.push_back('{3'd4, 2'd0, 2'd0, 1'b0, 1'b1, 7});
      vecs.push_back('{3'd4, 2'd0, 2'd0, 1'b0, 1'b0, 6});
`ifdef CTRL_STACK_EN
      vecs.push_back('{3'd5, 2'd0, 2'd0, 1'b0, 1'b0, 8});
      vecs.push_back('{3'd6, 2'd0, 2'd0, 1'b0, 1'b0, 9});
`endif

      bus_a.op_class = 3'd0; bus_a.addr_mode = 2'd0; bus_a.shift_kind = 2'd0;
      bus_a.dst_reg = 1'b0; bus_a.zero = 1'b0; bus_a.mem_ready = 1'b1;
      bus_b.op_class = 3'd2; bus_b.addr_mode = 2'd0; bus_b.shift_kind = 2'd0;
      bus_b.dst_reg = 1'b0; bus_b.zero = 1'b0; bus_b.mem_ready = 1'b1;
      reset_b = 1'b1;
      cur_sk = 2'd0;

      reset_a_seq();
      @(negedge clk);

      // Instruction table: each vector starts on the FETCH0 cycle
      for (int i = 0; i < vecs.size(); i++) begin
         bus_a.op_class = vecs[i].op; bus_a.addr_mode = vecs[i].am;
         bus_a.shift_kind = vecs[i].sk; bus_a.dst_reg = vecs[i].dst; bus_a.zero = vecs[i].z;
         cur_sk = vecs[i].sk;
         push_seq(vecs[i].op, vecs[i].am, vecs[i].dst, vecs[i].z);
         cyc = 0; done = 1'b0;
         while (!done) begin
            sb_check();
            cyc++;
            @(negedge clk);
            if (bus_a.irwrite == 4'b0001 || cyc >= 40) done = 1'b1;
         end
         check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].cycles));
         if (sb.size() != 0) fail($sformatf("vec%0d_short", i));
         sb.delete();
         $display("vec %0d: op_class=%0d addr_mode=%0d zero=%0d cycles=%0d", i, vecs[i].op,
                  vecs[i].am, vecs[i].z, cyc);
      end

      mem1_wait(3);
      mem1_wait(15);

`ifdef CTRL_STACK_EN
      stack_op(3'd5, 10);
      stack_op(3'd6, 11);
`else
      bus_a.op_class = 3'd5;
      repeat (5) @(negedge clk);
      check("nostack_err_state", 64'(bus_a.state), 64'd63);
      check("nostack_err_strobes", 64'(act_a), 64'(exp_vec(S_ERR, 2'd0)));
      $display("op_class 5 without stack: state=%0d timeout=%0d", bus_a.state, bus_a.timeout);
      reset_a_seq();
      @(negedge clk);
`endif

      bus_a.op_class = 3'd7;
      repeat (5) @(negedge clk);
      bus_a.op_class = 3'd0;
      for (int i = 0; i < 20; i++) begin
         check($sformatf("halt_hold%0d", i), 64'({bus_a.state, act_a}),
               64'({6'd31, exp_vec(S_HALT, 2'd0)}));
         @(negedge clk);
      end
      $display("halt: state=%0d halted=%0d", bus_a.state, bus_a.halted);
      reset_a_seq();
      @(negedge clk);

      bus_a.op_class = 3'd0; bus_a.addr_mode = 2'd3;
      cnt = 0;
      while (act_a != exp_vec(S_PCR3, 2'd0) && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= 20) fail("pcr3_reach");
      reset_a = 1'b1;
      @(negedge clk);
      check("midpcr3_state", 64'(bus_a.state), 64'd0);
      check("midpcr3_flags", 64'({bus_a.halted, bus_a.timeout}), 64'd0);
      check("midpcr3_strobes", 64'(act_a), 64'(exp_vec(S_SPINIT, 2'd0)));
      reset_a = 1'b0;
      @(negedge clk);
      check("restart_fetch0", 64'(act_a), 64'(exp_vec(S_F0, 2'd0)));
      $display("reset mid-PCR3: restarted at state %0d", bus_a.state);

      // Second configuration: 3-byte fetch, WAIT_MAX=4
      @(negedge clk);
      check("b_rst_state", 64'({bus_b.state, bus_b.ldSP}), 64'({6'd0, 1'b1}));
      reset_b = 1'b0;
      @(negedge clk);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (bus_b.irwrite != 3'b001 && cyc < 30);
      check("b_jmp_cycles", 64'(cyc), 64'd5);
      $display("b jmp: cycles=%0d", cyc);

      bus_b.op_class = 3'd0;
      repeat (2) @(negedge clk);
      check("b_fetch2", 64'({bus_b.irwrite, bus_b.adrend, bus_b.memread}),
            64'({3'b100, 2'd2, 1'b1}));
      bus_b.mem_ready = 1'b0;
      cnt = 0;
      while (bus_b.irwrite == 3'b100 && cnt < 30) begin
         @(negedge clk);
         cnt++;
      end
      check("b_held_cycles", 64'(cnt), 64'd5);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("b_err%0d", i),
               64'({bus_b.state, bus_b.timeout, bus_b.halted, bus_b.memread, bus_b.irwrite}),
               64'({6'd63, 1'b1, 1'b0, 1'b0, 3'b000}));
         @(negedge clk);
      end
      $display("b timeout: FETCH2 held %0d cycles, state=%0d", cnt, bus_b.state);
      reset_b = 1'b1;
      @(negedge clk);
      check("b_err_reset", 64'({bus_b.state, bus_b.timeout, bus_b.ldSP}),
            64'({6'd0, 1'b0, 1'b1}));
      reset_b = 1'b0;
      bus_b.mem_ready = 1'b1;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
